// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns and display constants shared by the
// seven-segment scan driver and its decoder. Patterns are active-low
// in {g,f,e,d,c,b,a} order for a common-anode display.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Index of the digit currently being scanned (0 = least significant).
  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: groups the digit inputs, scan enable and display outputs
// of the scan driver. The driver uses the slave view; whatever feeds the
// digits and watches the display uses the master view.
interface seg7_scan_if;

  logic       en;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output en, d0, d1, d2, d3, dp_mask,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  en, d0, d1, d2, d3, dp_mask,
    output an, seg, dp, frame_start
  );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: maps a 4-bit hex digit to its active-low segment pattern.
// A high blank input overrides the digit and turns every segment off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Table lookup for 0-F, with blanking taking priority over the digit.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'h0: seg_o = SEG_0;
        4'h1: seg_o = SEG_1;
        4'h2: seg_o = SEG_2;
        4'h3: seg_o = SEG_3;
        4'h4: seg_o = SEG_4;
        4'h5: seg_o = SEG_5;
        4'h6: seg_o = SEG_6;
        4'h7: seg_o = SEG_7;
        4'h8: seg_o = SEG_8;
        4'h9: seg_o = SEG_9;
        4'hA: seg_o = SEG_A;
        4'hB: seg_o = SEG_B;
        4'hC: seg_o = SEG_C;
        4'hD: seg_o = SEG_D;
        4'hE: seg_o = SEG_E;
        default: seg_o = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 4-digit common-anode display driver.
// A prescaler divides each digit slot into a dark ghost-suppression
// interval followed by the lit window. Digits and decimal points are
// copied into shadow registers once per frame so a counter rollover in
// the middle of a frame cannot tear the displayed number.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZB          = 1
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_if.slave   bus
);

  localparam int             PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  LAST_PRE  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]  BLANK_PRE = PW'(BLANK_CYCLES);

  logic [PW-1:0] pre_q, pre_d;
  digit_idx_t    idx_q, idx_d;
  logic [3:0]    s_q [4];
  logic [3:0]    s_d [4];
  logic [3:0]    sdp_q, sdp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic          snap;
  logic          lzb_blank;
  logic [6:0]    cur_seg;

  // A snapshot happens on the first enabled cycle of every frame.
  assign snap = bus.en && (idx_q == 2'd0) && (pre_q == '0);

  // Prescaler, digit index and shadow capture; everything holds while disabled.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    s_d   = s_q;
    sdp_d = sdp_q;
    if (bus.en) begin
      if (snap) begin
        s_d[0] = bus.d0;
        s_d[1] = bus.d1;
        s_d[2] = bus.d2;
        s_d[3] = bus.d3;
        sdp_d  = bus.dp_mask;
      end
      if (pre_q == LAST_PRE) begin
        pre_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Leading-zero suppression: a digit goes dark when it and every more
  // significant shadow digit are zero; the units digit always shows.
  always_comb begin
    lzb_blank = 1'b0;
    if (LZB != 0) begin
      case (idx_q)
        2'd3:    lzb_blank = (s_q[3] == 4'd0);
        2'd2:    lzb_blank = (s_q[3] == 4'd0) && (s_q[2] == 4'd0);
        2'd1:    lzb_blank = (s_q[3] == 4'd0) && (s_q[2] == 4'd0) && (s_q[1] == 4'd0);
        default: lzb_blank = 1'b0;
      endcase
    end
  end

  seg7_decode u_decode (
    .digit_i (s_q[idx_q]),
    .blank_i (lzb_blank),
    .seg_o   (cur_seg)
  );

  // Next display value: dark when disabled or in the blanking interval.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    fs_d  = 1'b0;
    if (bus.en) begin
      fs_d = snap;
      if (pre_q >= BLANK_PRE) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = cur_seg;
        dp_d  = ~sdp_q[idx_q];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= 2'd0;
      s_q   <= '{default: 4'd0};
      sdp_q <= 4'd0;
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      s_q   <= s_d;
      sdp_q <= sdp_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: drives two scan drivers (leading-zero blanking off and on)
// with the same digits and checks them every cycle against a frame-position
// model, plus literal expectations at hand-picked edges.
module tb_seg7_scan;

  localparam int SD    = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] d0, d1, d2, d3, dpMask;

  int assertions = 0;
  int failures   = 0;
  int edgeNum    = 0;
  int base       = 0;

  seg7_scan_if busA ();
  seg7_scan_if busB ();

  assign busA.en = en;  assign busA.d0 = d0;  assign busA.d1 = d1;
  assign busA.d2 = d2;  assign busA.d3 = d3;  assign busA.dp_mask = dpMask;
  assign busB.en = en;  assign busB.d0 = d0;  assign busB.d1 = d1;
  assign busB.d2 = d2;  assign busB.d3 = d3;  assign busB.dp_mask = dpMask;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BLANK), .LZB(0)) dutA (
    .clk (clk), .rst (rst), .bus (busA)
  );

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BLANK), .LZB(1)) dutB (
    .clk (clk), .rst (rst), .bus (busB)
  );

  always #5 clk = ~clk;

  logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic compareVal(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNum, act, exp);
    end
  endtask

  // Model state: enabled cycles since reset and the frame's captured digits.
  int unsigned t;
  logic [3:0]  ms [4];
  logic [3:0]  mdp;
  logic [3:0]  expAn;
  logic [6:0]  expSegA, expSegB;
  logic        expDp, expFs;

  // Model update on each edge, then compare both DUTs 1 time unit later.
  always @(posedge clk) begin
    int pos, di, pr, hi;
    logic [3:0] cur;
    expAn = 4'hF; expSegA = 7'h7F; expSegB = 7'h7F; expDp = 1'b1; expFs = 1'b0;
    if (rst) begin
      t = 0;
      ms = '{default: 4'd0};
      mdp = 4'd0;
    end else if (en) begin
      pos = int'(t % FRAME);
      di  = pos / SD;
      pr  = pos % SD;
      expFs = (pos == 0);
      if (pr >= BLANK) begin
        cur = ms[di];
        hi = -1;
        for (int k = 0; k < 4; k++) if (ms[k] != 4'd0) hi = k;
        expAn   = ~(4'b0001 << di);
        expSegA = segTab[cur];
        expSegB = (di > 0 && hi < di) ? 7'h7F : segTab[cur];
        expDp   = ~mdp[di];
      end
      if (pos == 0) begin
        ms[0] = d0; ms[1] = d1; ms[2] = d2; ms[3] = d3;
        mdp = dpMask;
      end
      t++;
    end
    #1;
    compareVal("modelA.an",  int'(busA.an),  int'(expAn));
    compareVal("modelA.seg", int'(busA.seg), int'(expSegA));
    compareVal("modelA.dp",  int'(busA.dp),  int'(expDp));
    compareVal("modelA.fs",  int'(busA.frame_start), int'(expFs));
    compareVal("modelB.an",  int'(busB.an),  int'(expAn));
    compareVal("modelB.seg", int'(busB.seg), int'(expSegB));
    compareVal("modelB.dp",  int'(busB.dp),  int'(expDp));
    compareVal("modelB.fs",  int'(busB.frame_start), int'(expFs));
    compareVal("anOneHotA",  int'($countones(~busA.an) <= 1), 1);
  end

  task automatic stepTo(input int n);
    while (edgeNum < n) begin
      @(negedge clk);
      edgeNum++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v3, input logic [3:0] v2,
                               input logic [3:0] v1, input logic [3:0] v0,
                               input logic [3:0] mask);
    d3 = v3; d2 = v2; d1 = v1; d0 = v0; dpMask = mask;
  endtask

  task automatic checkOutput(input string name, input bit useB, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp, input logic fs);
    if (useB) begin
      compareVal({name, ".an"},  int'(busB.an),  int'(an));
      compareVal({name, ".seg"}, int'(busB.seg), int'(seg));
      compareVal({name, ".dp"},  int'(busB.dp),  int'(dp));
      compareVal({name, ".fs"},  int'(busB.frame_start), int'(fs));
    end else begin
      compareVal({name, ".an"},  int'(busA.an),  int'(an));
      compareVal({name, ".seg"}, int'(busA.seg), int'(seg));
      compareVal({name, ".dp"},  int'(busA.dp),  int'(dp));
      compareVal({name, ".fs"},  int'(busA.frame_start), int'(fs));
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);

    // Scenario 1: counting display 3210.
    rst = 1'b0;
    en  = 1'b1;
    applyStimulus(4'd3, 4'd2, 4'd1, 4'd0, 4'b0000);
    stepTo(1);  checkOutput("e1",  1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
    stepTo(2);  checkOutput("e2",  1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    stepTo(3);  checkOutput("e3",  1'b0, 4'hE, 7'h40, 1'b1, 1'b0);
    stepTo(8);  checkOutput("e8",  1'b0, 4'hE, 7'h40, 1'b1, 1'b0);
    stepTo(9);  checkOutput("e9",  1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    stepTo(11); checkOutput("e11", 1'b0, 4'hD, 7'h79, 1'b1, 1'b0);
    stepTo(16); checkOutput("e16", 1'b0, 4'hD, 7'h79, 1'b1, 1'b0);
    stepTo(27); checkOutput("e27", 1'b0, 4'h7, 7'h30, 1'b1, 1'b0);
    stepTo(33); checkOutput("e33", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);

    // Snapshot isolation: 5 is captured at edge 65, 6 arrives mid-frame.
    applyStimulus(4'd3, 4'd2, 4'd1, 4'd5, 4'b0000);
    stepTo(70);  checkOutput("snap5", 1'b0, 4'hE, 7'h12, 1'b1, 1'b0);
    stepTo(76);  applyStimulus(4'd3, 4'd2, 4'd1, 4'd6, 4'b0000);
    stepTo(97);  checkOutput("snapFs", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
    stepTo(100); checkOutput("snap6", 1'b0, 4'hE, 7'h02, 1'b1, 1'b0);

    // Leading-zero blanking with 0007, then 0400.
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
    stepTo(132); checkOutput("lzb7.d0", 1'b1, 4'hE, 7'h78, 1'b1, 1'b0);
    stepTo(142); checkOutput("lzb7.d1", 1'b1, 4'hD, 7'h7F, 1'b1, 1'b0);
    stepTo(158); checkOutput("lzb7.d3", 1'b1, 4'h7, 7'h7F, 1'b1, 1'b0);
    checkOutput("nolzb.d3", 1'b0, 4'h7, 7'h40, 1'b1, 1'b0);
    stepTo(160); applyStimulus(4'd0, 4'd4, 4'd0, 4'd0, 4'b0000);
    stepTo(172); checkOutput("lzb400.d1", 1'b1, 4'hD, 7'h40, 1'b1, 1'b0);
    stepTo(190); checkOutput("lzb400.d3", 1'b1, 4'h7, 7'h7F, 1'b1, 1'b0);

    // Hex digit with its decimal point.
    stepTo(176); applyStimulus(4'd0, 4'd4, 4'd0, 4'hB, 4'b0001);
    stepTo(194); checkOutput("hexBlank", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    stepTo(195); checkOutput("hexB",     1'b0, 4'hE, 7'h03, 1'b0, 1'b0);
    stepTo(203); checkOutput("hexD1",    1'b0, 4'hD, 7'h40, 1'b1, 1'b0);

    // Enable gating mid-slot during digit 2's lit window.
    stepTo(212); checkOutput("preGate", 1'b0, 4'hB, 7'h19, 1'b1, 1'b0);
    en = 1'b0;
    stepTo(215); checkOutput("gated",   1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    stepTo(217); en = 1'b1;
    stepTo(218); checkOutput("resume",  1'b0, 4'hB, 7'h19, 1'b1, 1'b0);
    stepTo(221); checkOutput("resEnd",  1'b0, 4'hB, 7'h19, 1'b1, 1'b0);
    stepTo(222); checkOutput("nextSlot",1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    stepTo(230); checkOutput("gateFs",  1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);

    // Reset during digit 2's lit window, then rerun the first scenario.
    stepTo(249); checkOutput("preRst", 1'b0, 4'hB, 7'h19, 1'b1, 1'b0);
    rst = 1'b1;
    stepTo(250); checkOutput("midRst", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    applyStimulus(4'd3, 4'd2, 4'd1, 4'd0, 4'b0000);
    base = 250;
    stepTo(base + 1);  checkOutput("r1",  1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
    stepTo(base + 2);  checkOutput("r2",  1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    stepTo(base + 3);  checkOutput("r3",  1'b0, 4'hE, 7'h40, 1'b1, 1'b0);
    stepTo(base + 11); checkOutput("r11", 1'b0, 4'hD, 7'h79, 1'b1, 1'b0);
    stepTo(base + 27); checkOutput("r27", 1'b0, 4'h7, 7'h30, 1'b1, 1'b0);
    stepTo(base + 33); checkOutput("r33", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed 4-digit seven-segment driver that consumes the four 4-bit digit outputs of the synchronous decade counter and drives a common-anode display. It cycles one digit per scan slot and inserts a ghost-suppression blanking interval at the start of each slot. Digits are snapshotted once per frame so a counter rollover cannot tear the displayed value. Leading-zero blanking and per-digit decimal points are supported.

## Interface

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < SCAN_DIV.
- LZB, 1, enables leading-zero blanking when 1.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; when 0, scan state holds and the display is dark.
- d0  in  4  least-significant digit (q0 of the counter).
- d1  in  4  digit 1.
- d2  in  4  digit 2.
- d3  in  4  most-significant digit.
- dp_mask  in  4  decimal point for digit i is lit when dp_mask[i]=1; sampled with the digit snapshot.
- an  out  4  anode enables, active-low; an[i] selects digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse marking each digit snapshot.

## Operation

- State: prescaler pre (0..SCAN_DIV-1), digit index idx (0..3), shadow digits s0..s3, shadow mask sdp.
- Each cycle with en=1, pre increments. At SCAN_DIV-1, pre wraps to 0 and idx advances 0→1→2→3→0.
- Snapshot: on any cycle with en=1, idx=0 and pre=0, s0..s3 ← d0..d3, sdp ← dp_mask, and frame_start is asserted on the next cycle. After reset the first enabled cycle is a snapshot cycle.
- en=0: pre, idx and the shadow registers hold. The next cycle drives an=1111, seg=7F, dp=1 and frame_start=0.
- Display is computed from the current state and registered (one-cycle latency):
  - Blank when pre < BLANK_CYCLES: an=1111, seg=7F, dp=1.
  - Otherwise an = ~(1<<idx), seg = decode(s_idx), dp = ~sdp[idx].
- Decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
- Leading-zero blanking (LZB=1) forces seg=7F for a digit while its anode remains driven. The dp bit is not affected.
  - Digit 3 is blanked if s3=0.
  - Digit 2 is blanked if s3=s2=0.
  - Digit 1 is blanked if s3=s2=s1=0.
  - Digit 0 is never blanked.
- Reset values: pre=0, idx=0, s0..s3=0, sdp=0, an=1111, seg=7F, dp=1, frame_start=0.
- Reset mid-slot returns the block to the reset values on the next edge, with no partial-slot completion.

## Timing

- Slot length is SCAN_DIV cycles. Lit time per slot is SCAN_DIV−BLANK_CYCLES. The frame is 4·SCAN_DIV cycles.
- Edge numbering: rst is low and en is high from edge 1. Outputs at edge n reflect the state before edge n.
  - frame_start is high after edge 1, then after every 4·SCAN_DIV further edges.
  - an is lit for idx=0 from edge BLANK_CYCLES+1 through edge SCAN_DIV.
- A change on d0..d3 between snapshots is not visible until the next frame. A change on the snapshot cycle itself is captured.
- an never has more than one bit low in any cycle.

## Structure

- Package seg7_pkg holds the 16 segment-pattern constants, SEG_BLANK=7'h7F and AN_OFF=4'hF.
- Sub-module seg7_decode maps a 4-bit digit and a blank input to a 7-bit pattern, using the package constants.
- seg7_scan holds the prescaler, index, shadow registers, LZB logic and output registers.

## Test plan

- Reset and enable, with SCAN_DIV=8, BLANK_CYCLES=2, d={3,2,1,0}, LZB=0, rst then en=1:
  - Edges 1–2: an=1111.
  - Edges 3–8: an=1110, seg=40.
  - Edges 9–10: an=1111.
  - Edges 11–16: an=1101, seg=79.
  - Digit 3 shows seg=30.
- Snapshot isolation: change d0 from 5 to 6 at edge 12 of the frame. The remainder of the frame shows 5 on digit 0; the next frame shows 6 (seg=02).
- Leading-zero blanking, LZB=1:
  - d={0,0,0,7}: digits 3–1 give seg=7F with their anodes still low; digit 0 gives seg=78.
  - d={0,4,0,0}: digit 1 gives seg=40.
- Hex and dp: d0=B with dp_mask=0001 gives seg=03 and dp=0 only during digit 0's lit window.
- Enable gating: drop en mid-slot for 5 cycles. Outputs are dark, the state holds, and the slot resumes with its remaining lit cycles intact after en returns.
- Reset mid-operation: assert rst during digit 2's lit window. After the next edge all outputs are at reset values, and the sequence restarts exactly as in the first scenario.
